conversor_bcd_seq: RTL and testbench



---
 rtl/conversor_bcd_seq_pkg.sv | 21 ++
 rtl/conversor_bcd_seq_corretor_digito.sv | 24 ++
 rtl/conversor_bcd_seq.sv | 183 ++++++++++++++++++
 tb/tb_conversor_bcd_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conversor_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// conversor_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   estado_t        - controller states (OCIOSO, DESLOCA, FIM)
//   BCD_LARG        - bits per BCD digit
//   LIMIAR_CORRECAO - digit value from which the add-3 correction applies
//   CORRECAO        - amount added to a digit before each shift
// -----------------------------------------------------------------------------
package conversor_bcd_seq_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int BCD_LARG        = 4;
    localparam int LIMIAR_CORRECAO = 5;
    localparam int CORRECAO        = 3;

endpackage

// File: rtl/conversor_bcd_seq_corretor_digito.sv
// -----------------------------------------------------------------------------
// corretor_digito
// Single-digit double-dabble correction: adds 3 to a BCD digit whose value is
// 5 or more, so that the following left shift carries into the next digit.
// Ports:
//   digito_i - 4-bit digit before correction
//   digito_o - 4-bit digit after correction (no carry out)
// -----------------------------------------------------------------------------
module corretor_digito
    import conversor_bcd_seq_pkg::*;
(
    input  logic [BCD_LARG-1:0] digito_i,
    output logic [BCD_LARG-1:0] digito_o
);

    always_comb begin
        if (digito_i >= BCD_LARG'(LIMIAR_CORRECAO)) begin
            digito_o = digito_i + BCD_LARG'(CORRECAO);
        end else begin
            digito_o = digito_i;
        end
    end

endmodule

// File: rtl/conversor_bcd_seq.sv
// -----------------------------------------------------------------------------
// conversor_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with optional two's-complement input and an overflow flag.
// Parameters:
//   LARGURA - input word width in bits (>= 2)
//   DIGITOS - number of BCD output digits (>= 1)
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   inicio     - start request, honoured only while idle
//   entrada    - binary operand, captured with inicio
//   modo_sinal - 1: entrada is two's complement; captured with inicio
//   ocupado    - conversion in progress
//   pronto     - one-cycle pulse, result registers updated this cycle
//   bcd        - packed BCD result, units digit in bits [3:0]
//   negativo   - sign of the last result
//   estouro    - last magnitude did not fit in DIGITOS digits
// -----------------------------------------------------------------------------
module conversor_bcd_seq
    import conversor_bcd_seq_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int DIGITOS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inicio,
    input  logic [LARGURA-1:0]          entrada,
    input  logic                        modo_sinal,
    output logic                        ocupado,
    output logic                        pronto,
    output logic [BCD_LARG*DIGITOS-1:0] bcd,
    output logic                        negativo,
    output logic                        estouro
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam int SW = BCD_LARG * DIGITOS;

    // Controller
    estado_t estado_q;
    estado_t estado_d;

    logic captura;
    logic desloca;
    logic carrega;

    // Conversion scratch state
    logic [CW-1:0]      contador_q;
    logic [CW-1:0]      contador_d;
    logic [SW-1:0]      rascunho_q;
    logic [SW-1:0]      rascunho_d;
    logic [LARGURA-1:0] magnitude_q;
    logic [LARGURA-1:0] magnitude_d;
    logic               sinal_q;
    logic               sinal_d;
    logic               estouro_int_q;
    logic               estouro_int_d;

    // Visible result registers
    logic [SW-1:0]      bcd_q;
    logic               negativo_q;
    logic               estouro_q;
    logic               pronto_q;

    // Scratch digits after the add-3 correction
    logic [SW-1:0]      corrigido;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITOS; gi++) begin : g_corretor
            corretor_digito u_corretor (
                .digito_i (rascunho_q[gi*BCD_LARG +: BCD_LARG]),
                .digito_o (corrigido[gi*BCD_LARG +: BCD_LARG])
            );
        end
    endgenerate

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    estado_d = DESLOCA;
                end
            end
            DESLOCA: begin
                // Counter at 1 means this edge performs the last shift.
                if (contador_q == CW'(1)) begin
                    estado_d = FIM;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        ocupado = (estado_q != OCIOSO);
        captura = (estado_q == OCIOSO) && inicio;
        desloca = (estado_q == DESLOCA);
        carrega = (estado_q == FIM);
    end

    // ----------------------------------------------------------- Datapath ---
    always_comb begin
        contador_d    = contador_q;
        rascunho_d    = rascunho_q;
        magnitude_d   = magnitude_q;
        sinal_d       = sinal_q;
        estouro_int_d = estouro_int_q;

        if (captura) begin
            // Negating the most negative value wraps back onto itself, which
            // read as unsigned is exactly the required magnitude 2^(LARGURA-1).
            sinal_d       = modo_sinal && entrada[LARGURA-1];
            magnitude_d   = sinal_d ? (~entrada + LARGURA'(1)) : entrada;
            rascunho_d    = '0;
            estouro_int_d = 1'b0;
            contador_d    = CW'(LARGURA);
        end else if (desloca) begin
            rascunho_d    = {corrigido[SW-2:0], magnitude_q[LARGURA-1]};
            magnitude_d   = {magnitude_q[LARGURA-2:0], 1'b0};
            // Any 1 leaving the top digit means the value needs more digits.
            estouro_int_d = estouro_int_q | corrigido[SW-1];
            contador_d    = contador_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador_q    <= '0;
            rascunho_q    <= '0;
            magnitude_q   <= '0;
            sinal_q       <= 1'b0;
            estouro_int_q <= 1'b0;
        end else begin
            contador_q    <= contador_d;
            rascunho_q    <= rascunho_d;
            magnitude_q   <= magnitude_d;
            sinal_q       <= sinal_d;
            estouro_int_q <= estouro_int_d;
        end
    end

    // Results are loaded on the edge that leaves FIM, so pronto rises
    // together with the new values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q      <= '0;
            negativo_q <= 1'b0;
            estouro_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            pronto_q <= carrega;
            if (carrega) begin
                bcd_q      <= rascunho_q;
                negativo_q <= sinal_q;
                estouro_q  <= estouro_int_q;
            end
        end
    end

    assign pronto   = pronto_q;
    assign bcd      = bcd_q;
    assign negativo = negativo_q;
    assign estouro  = estouro_q;

endmodule

// File: tb/tb_conversor_bcd_seq.sv
module tb_conversor_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio_a, inicio_b, inicio_c;
    logic [15:0] entrada;
    logic        modo;

    logic        ocupado_a, pronto_a, negativo_a, estouro_a;
    logic [11:0] bcd_a;
    logic        ocupado_b, pronto_b, negativo_b, estouro_b;
    logic [7:0]  bcd_b;
    logic        ocupado_c, pronto_c, negativo_c, estouro_c;
    logic [19:0] bcd_c;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic        ocupado_s, pronto_s, negativo_s, estouro_s;
    logic [19:0] bcd_s;

    always #5 clk = ~clk;

    conversor_bcd_seq #(.LARGURA(8), .DIGITOS(3)) dut_a (
        .clk(clk), .reset(reset), .inicio(inicio_a), .entrada(entrada[7:0]),
        .modo_sinal(modo), .ocupado(ocupado_a), .pronto(pronto_a),
        .bcd(bcd_a), .negativo(negativo_a), .estouro(estouro_a));

    conversor_bcd_seq #(.LARGURA(8), .DIGITOS(2)) dut_b (
        .clk(clk), .reset(reset), .inicio(inicio_b), .entrada(entrada[7:0]),
        .modo_sinal(modo), .ocupado(ocupado_b), .pronto(pronto_b),
        .bcd(bcd_b), .negativo(negativo_b), .estouro(estouro_b));

    conversor_bcd_seq #(.LARGURA(16), .DIGITOS(5)) dut_c (
        .clk(clk), .reset(reset), .inicio(inicio_c), .entrada(entrada),
        .modo_sinal(modo), .ocupado(ocupado_c), .pronto(pronto_c),
        .bcd(bcd_c), .negativo(negativo_c), .estouro(estouro_c));

    always_comb begin
        ocupado_s  = ocupado_a;
        pronto_s   = pronto_a;
        negativo_s = negativo_a;
        estouro_s  = estouro_a;
        bcd_s      = {8'h00, bcd_a};
        if (sel == 1) begin
            ocupado_s  = ocupado_b;
            pronto_s   = pronto_b;
            negativo_s = negativo_b;
            estouro_s  = estouro_b;
            bcd_s      = {12'h000, bcd_b};
        end else if (sel == 2) begin
            ocupado_s  = ocupado_c;
            pronto_s   = pronto_c;
            negativo_s = negativo_c;
            estouro_s  = estouro_c;
            bcd_s      = bcd_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inicio(input int s, input logic v);
        case (s)
            0: inicio_a = v;
            1: inicio_b = v;
            default: inicio_c = v;
        endcase
    endtask

    function automatic int largura_de(input int s);
        return (s == 2) ? 16 : 8;
    endfunction

    function automatic int digitos_de(input int s);
        return (s == 0) ? 3 : ((s == 1) ? 2 : 5);
    endfunction

    // Reference model: plain arithmetic on the integer value.
    function automatic longint magnitude_ref(input int s, input logic [15:0] v, input logic m);
        longint w   = largura_de(s);
        longint val = longint'(v) & ((64'd1 << w) - 1);
        if (m && val >= (64'd1 << (w - 1))) begin
            return (64'd1 << w) - val;
        end
        return val;
    endfunction

    function automatic logic [19:0] bcd_ref(input longint mag, input int dig);
        logic [19:0] r = '0;
        longint      x = mag;
        for (int i = 0; i < dig; i++) begin
            r = r | (20'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint pot10(input int dig);
        longint p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        return p;
    endfunction

    // Called #1 after the edge that sampled inicio; counts edges until pronto.
    task automatic wait_pronto(output int n, output int ocup);
        n    = 0;
        ocup = ocupado_s ? 1 : 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (pronto_s) break;
            if (ocupado_s) ocup++;
        end
    endtask

    task automatic run(input int s, input logic [15:0] v, input logic m);
        int          n, ocup, w;
        longint      mag;
        logic [19:0] exp_bcd;
        logic        exp_neg, exp_est;
        string       t;
        w       = largura_de(s);
        mag     = magnitude_ref(s, v, m);
        exp_bcd = bcd_ref(mag, digitos_de(s));
        exp_est = (mag >= pot10(digitos_de(s)));
        exp_neg = m && v[w-1];
        @(negedge clk);
        sel     = s;
        entrada = v;
        modo    = m;
        set_inicio(s, 1'b1);
        @(posedge clk);
        #1;
        set_inicio(s, 1'b0);
        wait_pronto(n, ocup);
        t = $sformatf("dut%0d v=%0h m=%0d", s, v, m);
        check({t, " latency"}, 32'(n), 32'(w + 1));
        check({t, " busy_cycles"}, 32'(ocup), 32'(w + 1));
        check({t, " bcd"}, {12'h0, bcd_s}, {12'h0, exp_bcd});
        check({t, " negativo"}, {31'h0, negativo_s}, {31'h0, exp_neg});
        check({t, " estouro"}, {31'h0, estouro_s}, {31'h0, exp_est});
        check({t, " ocupado_at_pronto"}, {31'h0, ocupado_s}, 32'h0);
        @(posedge clk);
        #1;
        check({t, " pronto_pulse"}, {31'h0, pronto_s}, 32'h0);
        $display("conv %s -> bcd=%h neg=%0d est=%0d latency=%0d", t, bcd_s, negativo_s, estouro_s, n);
    endtask

    initial begin
        int n, ocup, cnt;
        reset    = 1'b1;
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        inicio_c = 1'b0;
        entrada  = '0;
        modo     = 1'b0;
        #12;
        check("reset bcd_a", {20'h0, bcd_a}, 32'h0);
        check("reset flags_a", {28'h0, ocupado_a, pronto_a, negativo_a, estouro_a}, 32'h0);
        check("reset bcd_c", {12'h0, bcd_c}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run(0, 16'd255, 1'b0);
        run(0, 16'h0080, 1'b1);
        run(0, 16'h00FF, 1'b1);
        run(0, 16'h0000, 1'b1);
        run(0, 16'h007F, 1'b1);
        run(1, 16'd200, 1'b0);
        run(1, 16'd99, 1'b0);
        run(1, 16'd100, 1'b0);
        run(2, 16'd65535, 1'b0);
        run(2, 16'd10000, 1'b0);
        run(2, 16'h8000, 1'b1);

        // Randomized cases
        for (int i = 0; i < 30; i++) begin
            run(i % 3, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // inicio pulsed while busy must be ignored
        sel = 0;
        @(negedge clk);
        entrada  = 16'd255;
        modo     = 1'b0;
        inicio_a = 1'b1;
        @(posedge clk);
        #1;
        inicio_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        entrada  = 16'd7;
        inicio_a = 1'b1;
        @(negedge clk);
        inicio_a = 1'b0;
        wait_pronto(n, ocup);
        check("busy pronto_seen", {31'h0, pronto_a}, 32'h1);
        check("busy bcd", {20'h0, bcd_a}, 32'h255);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (pronto_a) cnt++;
        end
        check("busy no_second_pronto", 32'(cnt), 32'h0);
        $display("busy test bcd=%h extra_pronto=%0d", bcd_a, cnt);

        // Back-to-back with inicio held high
        @(negedge clk);
        entrada  = 16'd123;
        inicio_a = 1'b1;
        @(posedge clk);
        #1;
        wait_pronto(n, ocup);
        check("b2b first bcd", {20'h0, bcd_a}, 32'h123);
        entrada = 16'd45;
        @(posedge clk);
        #1;
        check("b2b restart ocupado", {31'h0, ocupado_a}, 32'h1);
        inicio_a = 1'b0;
        wait_pronto(n, ocup);
        check("b2b second latency", 32'(n), 32'd9);
        check("b2b second bcd", {20'h0, bcd_a}, 32'h045);
        $display("b2b test bcd=%h latency=%0d", bcd_a, n);
        @(posedge clk);

        // Asynchronous reset mid-conversion
        run(0, 16'd42, 1'b0);
        @(negedge clk);
        entrada  = 16'd255;
        inicio_a = 1'b1;
        @(posedge clk);
        #1;
        inicio_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midreset ocupado_before", {31'h0, ocupado_a}, 32'h1);
        reset = 1'b1;
        #1;
        check("midreset bcd", {20'h0, bcd_a}, 32'h0);
        check("midreset flags", {28'h0, ocupado_a, pronto_a, negativo_a, estouro_a}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (pronto_a) cnt++;
        end
        check("midreset no_pronto", 32'(cnt), 32'h0);
        $display("reset test extra_pronto=%0d", cnt);
        run(0, 16'd255, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
